// File: rtl/core_pkg.sv
// Core-wide architectural widths shared by pipeline control blocks.
package core_pkg;

    localparam int unsigned RF_ADDR_WIDTH  = 5;
    localparam int unsigned CSR_ADDR_WIDTH = 12;

endpackage

// File: rtl/ctrl_sb_pkg.sv
// Types shared between the issue stage and the hazard scoreboard.
package ctrl_sb_pkg;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_ctrl_t;

    typedef struct packed {
        logic [core_pkg::RF_ADDR_WIDTH-1:0]  rd;
        logic [core_pkg::CSR_ADDR_WIDTH-1:0] csr_waddr;
        csr_ctrl_t                           csr_ctrl;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-order tracker of in-flight GPR/CSR writers; flags RAW hazards for the
// instruction currently in decode.
module hazard_scoreboard
    import core_pkg::*;
    import ctrl_sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NB_RS = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              issue_valid_i,
    output logic                              issue_ready_o,
    input  sb_entry_t                         issue_i,
    input  logic                              retire_valid_i,
    input  logic                              flush_i,
    input  logic [NB_RS*RF_ADDR_WIDTH-1:0]    rs_i,
    input  logic [CSR_ADDR_WIDTH-1:0]         csr_raddr_i,
    input  logic                              csr_rd_en_i,
    output logic [NB_RS-1:0]                  rs_hazard_o,
    output logic                              csr_hazard_o,
    output logic [$clog2(DEPTH+1)-1:0]        count_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic                              underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entry_q [DEPTH];
    sb_entry_t        entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             underflow_q, underflow_d;
    logic             push_c, pop_c;

    // Explicit wrap so non-power-of-two depths cycle correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign issue_ready_o = !full_q || retire_valid_i;
    assign push_c        = issue_valid_i && issue_ready_o;
    assign pop_c         = retire_valid_i && !empty_q;

    always_comb begin
        entry_d     = entry_q;
        valid_d     = valid_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        underflow_d = retire_valid_i && empty_q;
        if (flush_i) begin
            valid_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Pop before push so a full-buffer replace leaves the slot valid.
            if (pop_c) begin
                valid_d[rptr_q] = 1'b0;
                rptr_d          = ptr_inc(rptr_q);
            end
            if (push_c) begin
                entry_d[wptr_q] = issue_i;
                valid_d[wptr_q] = 1'b1;
                wptr_d          = ptr_inc(wptr_q);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < DEPTH; e++) begin
                entry_q[e] <= '0;
            end
            valid_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            valid_q     <= valid_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign underflow_o = underflow_q;

    // GPR comparators: x0 never creates a dependency.
    for (genvar g = 0; g < NB_RS; g++) begin : g_rs
        logic [RF_ADDR_WIDTH-1:0] rs_idx;
        logic                     hit;

        assign rs_idx = rs_i[g*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];

        always_comb begin
            hit = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && (rs_idx != '0) && (entry_q[e].rd == rs_idx)) begin
                    hit = 1'b1;
                end
            end
        end

        assign rs_hazard_o[g] = hit;
    end

    always_comb begin
        csr_hazard_o = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (csr_rd_en_i && valid_q[e] && (entry_q[e].csr_ctrl != CSR_NONE) &&
                (entry_q[e].csr_waddr == csr_raddr_i)) begin
                csr_hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus queues expectations tagged by cycle, a negedge
// monitor pops and compares them against a DEPTH=4 and a DEPTH=3 instance.
module tb_hazard_scoreboard;
    import core_pkg::*;
    import ctrl_sb_pkg::*;

    typedef enum int {F_COUNT, F_FULL, F_EMPTY, F_READY, F_RSHAZ, F_CSRHAZ, F_UNDER} fld_e;
    typedef struct {
        int   cyc;
        int   inst;
        fld_e f;
        int   v;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic                           iv4, ret4, iv3, ret3, fl, crd;
    sb_entry_t                      ent4, ent3;
    logic [2*RF_ADDR_WIDTH-1:0]     rs;
    logic [CSR_ADDR_WIDTH-1:0]      craddr;

    logic       ready4, csrhaz4, full4, empty4, und4;
    logic [1:0] rshaz4;
    logic [2:0] cnt4;
    logic       ready3, csrhaz3, full3, empty3, und3;
    logic [1:0] rshaz3;
    logic [1:0] cnt3;

    hazard_scoreboard #(.DEPTH(4), .NB_RS(2)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .issue_valid_i(iv4), .issue_ready_o(ready4), .issue_i(ent4),
        .retire_valid_i(ret4), .flush_i(fl), .rs_i(rs),
        .csr_raddr_i(craddr), .csr_rd_en_i(crd),
        .rs_hazard_o(rshaz4), .csr_hazard_o(csrhaz4), .count_o(cnt4),
        .full_o(full4), .empty_o(empty4), .underflow_o(und4)
    );

    hazard_scoreboard #(.DEPTH(3), .NB_RS(2)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .issue_valid_i(iv3), .issue_ready_o(ready3), .issue_i(ent3),
        .retire_valid_i(ret3), .flush_i(fl), .rs_i(rs),
        .csr_raddr_i(craddr), .csr_rd_en_i(crd),
        .rs_hazard_o(rshaz3), .csr_hazard_o(csrhaz3), .count_o(cnt3),
        .full_o(full3), .empty_o(empty3), .underflow_o(und3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(int inst, fld_e f);
        if (inst == 0) begin
            case (f)
                F_COUNT:  return int'(cnt4);
                F_FULL:   return int'(full4);
                F_EMPTY:  return int'(empty4);
                F_READY:  return int'(ready4);
                F_RSHAZ:  return int'(rshaz4);
                F_CSRHAZ: return int'(csrhaz4);
                default:  return int'(und4);
            endcase
        end
        case (f)
            F_COUNT:  return int'(cnt3);
            F_FULL:   return int'(full3);
            F_EMPTY:  return int'(empty3);
            F_READY:  return int'(ready3);
            F_RSHAZ:  return int'(rshaz3);
            F_CSRHAZ: return int'(csrhaz3);
            default:  return int'(und3);
        endcase
    endfunction

    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].cyc <= cyc) begin
            exp_t  e;
            string n;
            int    a;
            e = eq.pop_front();
            n = nq.pop_front();
            a = actual(e.inst, e.f);
            checks++;
            if (a != e.v) begin
                errors++;
                $display("FAIL %s (cycle %0d, dut%0d): got %0d expected %0d",
                         n, e.cyc, (e.inst == 0) ? 4 : 3, a, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int inst, input fld_e f, input int v, input string n);
        exp_t e;
        e = '{cyc, inst, f, v};
        eq.push_back(e);
        nq.push_back(n);
    endtask

    task automatic set_rs(input int r0, input int r1);
        rs = {RF_ADDR_WIDTH'(r1), RF_ADDR_WIDTH'(r0)};
    endtask

    function automatic sb_entry_t mk(input int rd, input int waddr, input csr_ctrl_t c);
        sb_entry_t s;
        s.rd        = RF_ADDR_WIDTH'(rd);
        s.csr_waddr = CSR_ADDR_WIDTH'(waddr);
        s.csr_ctrl  = c;
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        iv4 = 1'b0; ret4 = 1'b0; iv3 = 1'b0; ret3 = 1'b0; fl = 1'b0; crd = 1'b0;
        ent4 = mk(0, 0, CSR_NONE); ent3 = mk(0, 0, CSR_NONE);
        craddr = '0;
        set_rs(5, 3);

        // Reset values
        tick();
        expect_v(0, F_COUNT, 0, "rst_count");
        expect_v(0, F_EMPTY, 1, "rst_empty");
        expect_v(0, F_FULL, 0, "rst_full");
        expect_v(0, F_READY, 1, "rst_ready");
        expect_v(0, F_RSHAZ, 0, "rst_rshaz");
        expect_v(0, F_CSRHAZ, 0, "rst_csrhaz");
        expect_v(0, F_UNDER, 0, "rst_under");
        expect_v(1, F_COUNT, 0, "rst_count_d3");
        tick();
        rstn = 1'b1;
        tick();

        // Basic GPR RAW: rs[0]=5 matches rd=5
        iv4 = 1'b1; ent4 = mk(5, 0, CSR_NONE); set_rs(5, 3);
        expect_v(0, F_RSHAZ, 0, "push_same_cycle_no_haz");
        tick();
        iv4 = 1'b0;
        expect_v(0, F_COUNT, 1, "count_after_push");
        expect_v(0, F_RSHAZ, 1, "raw_rd5");
        ret4 = 1'b1;
        tick();
        ret4 = 1'b0;
        expect_v(0, F_RSHAZ, 0, "haz_clear_after_retire");
        expect_v(0, F_COUNT, 0, "count_after_retire");
        tick();

        // Fill DEPTH=4, then replace-on-full
        for (int k = 1; k <= 4; k++) begin
            iv4 = 1'b1; ent4 = mk(k, 0, CSR_NONE);
            tick();
        end
        iv4 = 1'b0; set_rs(1, 4);
        expect_v(0, F_FULL, 1, "full_at_4");
        expect_v(0, F_READY, 0, "not_ready_when_full");
        expect_v(0, F_COUNT, 4, "count_4");
        expect_v(0, F_RSHAZ, 3, "both_rs_haz_full");
        tick();
        iv4 = 1'b1; ent4 = mk(7, 0, CSR_NONE); ret4 = 1'b1;
        expect_v(0, F_READY, 1, "ready_full_with_retire");
        tick();
        iv4 = 1'b0; ret4 = 1'b0; set_rs(1, 7);
        expect_v(0, F_COUNT, 4, "count_held_on_replace");
        expect_v(0, F_FULL, 1, "full_held_on_replace");
        expect_v(0, F_RSHAZ, 2, "oldest_replaced");
        ret4 = 1'b1;
        repeat (4) tick();
        ret4 = 1'b0;
        expect_v(0, F_COUNT, 0, "drained_count");
        expect_v(0, F_EMPTY, 1, "drained_empty");
        tick();

        // Underflow pulse
        ret4 = 1'b1;
        expect_v(0, F_UNDER, 0, "under_registered");
        tick();
        ret4 = 1'b0;
        expect_v(0, F_UNDER, 1, "under_pulse");
        expect_v(0, F_COUNT, 0, "under_count_0");
        tick();
        expect_v(0, F_UNDER, 0, "under_one_cycle");
        tick();

        // CSR hazard plus an rd=0 entry with no CSR write
        iv4 = 1'b1; ent4 = mk(0, 'h300, CSR_WRITE);
        tick();
        ent4 = mk(0, 0, CSR_NONE); crd = 1'b1; craddr = 'h300; set_rs(0, 0);
        expect_v(0, F_CSRHAZ, 1, "csr_raw_300");
        expect_v(0, F_RSHAZ, 0, "rd0_no_gpr_haz");
        tick();
        iv4 = 1'b0; craddr = 'h301;
        expect_v(0, F_CSRHAZ, 0, "csr_301_no_haz");
        tick();
        craddr = '0;
        expect_v(0, F_CSRHAZ, 0, "rd0_csrnone_no_csr_haz");
        expect_v(0, F_COUNT, 2, "rd0_csrnone_tracked");
        ret4 = 1'b1;
        tick();
        tick();
        ret4 = 1'b0; crd = 1'b0;
        expect_v(0, F_COUNT, 0, "csr_drained");
        tick();

        // Flush overrides a same-cycle push
        for (int k = 10; k <= 12; k++) begin
            iv4 = 1'b1; ent4 = mk(k, 0, CSR_NONE);
            tick();
        end
        ent4 = mk(13, 'h300, CSR_WRITE); fl = 1'b1; set_rs(10, 12);
        expect_v(0, F_COUNT, 3, "pre_flush_count");
        expect_v(0, F_RSHAZ, 3, "pre_flush_haz");
        tick();
        iv4 = 1'b0; fl = 1'b0; set_rs(10, 13); crd = 1'b1; craddr = 'h300;
        expect_v(0, F_COUNT, 0, "flush_count");
        expect_v(0, F_EMPTY, 1, "flush_empty");
        expect_v(0, F_RSHAZ, 0, "flush_rshaz");
        expect_v(0, F_CSRHAZ, 0, "flush_csrhaz");
        tick();
        crd = 1'b0;

        // Asynchronous reset mid-operation
        iv4 = 1'b1; ent4 = mk(9, 0, CSR_NONE);
        tick();
        tick();
        iv4 = 1'b0; set_rs(9, 0);
        expect_v(0, F_COUNT, 2, "pre_reset_count");
        expect_v(0, F_RSHAZ, 1, "pre_reset_haz");
        tick();
        rstn = 1'b0;
        expect_v(0, F_COUNT, 0, "async_rst_count");
        expect_v(0, F_EMPTY, 1, "async_rst_empty");
        expect_v(0, F_READY, 1, "async_rst_ready");
        expect_v(0, F_RSHAZ, 0, "async_rst_haz");
        tick();
        rstn = 1'b1;
        tick();

        // DEPTH=3: seven issue/retire pairs wrap both pointers
        for (int k = 0; k < 7; k++) begin
            iv3 = 1'b1; ent3 = mk(20 + k, 0, CSR_NONE);
            tick();
            iv3 = 1'b0; ret3 = 1'b1; set_rs(20 + k, 19 + k);
            expect_v(1, F_COUNT, 1, "d3_count_1");
            expect_v(1, F_RSHAZ, 1, "d3_haz_live_only");
            tick();
            ret3 = 1'b0;
        end
        set_rs(26, 25);
        expect_v(1, F_COUNT, 0, "d3_count_0");
        expect_v(1, F_EMPTY, 1, "d3_empty");
        expect_v(1, F_RSHAZ, 0, "d3_no_spurious_haz");
        tick();

        for (int i = 0; i < 4 && eq.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", eq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
